sudoku_scan_controller: RTL and testbench

//  Iterates the combinational/registered Scanner constraint-propagation datapath over a 9x9

---
 rtl/sudoku_pkg.sv | 25 ++
 rtl/sudoku_scan_controller_grid_checker.sv | 25 ++
 rtl/sudoku_scan_controller.sv | 136 +++++++++++++
 tb/tb_sudoku_scan_controller.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sudoku_pkg.sv
// Shared types for the sudoku scan controller slice.
// Grid layout: band, box column, cell within box.
package sudoku_pkg;

  typedef logic [8:0] cell_t;
  typedef cell_t [2:0][2:0][8:0] grid_t;

  localparam cell_t ALL_CAND = 9'h1FF;

  typedef enum logic [2:0] {
    NONE    = 3'd0,
    SOLVED  = 3'd1,
    STUCK   = 3'd2,
    CONTRA  = 3'd3,
    TIMEOUT = 3'd4,
    ABORTED = 3'd5
  } status_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sudoku_scan_controller_grid_checker.sv
// Combinational grid summary: any empty cell,
// and whether every cell holds exactly one candidate.
module grid_checker
  import sudoku_pkg::*;
(
  input  grid_t i_Grid,
  output logic  o_Any_Empty,
  output logic  o_All_Single
);

  // Reduce all 81 cells into the two flags.
  always_comb begin
    o_Any_Empty  = 1'b0;
    o_All_Single = 1'b1;
    for (int b = 0; b < 3; b++) begin
      for (int c = 0; c < 3; c++) begin
        for (int k = 0; k < 9; k++) begin
          o_Any_Empty  |= (i_Grid[b][c][k] == '0);
          o_All_Single &= $onehot(i_Grid[b][c][k]);
        end
      end
    end
  end

endmodule

// File: rtl/sudoku_scan_controller.sv
// Iterates the scanner datapath over the working grid
// until solved, stuck, contradictory, timed out or aborted.
module sudoku_scan_controller
  import sudoku_pkg::*;
#(
  parameter  int SCAN_LATENCY = 1,
  parameter  int MAX_ITER     = 81,
  localparam int ITER_W       = $clog2(MAX_ITER + 1)
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_Start,
  input  logic              i_Abort,
  input  grid_t             i_Grid,
  input  grid_t             i_Scan_Grid,
  output grid_t             o_Grid,
  output logic              o_Busy,
  output logic              o_Done,
  output status_t           o_Status,
  output logic [ITER_W-1:0] o_Iter
);

  localparam int CNT_W =
    (SCAN_LATENCY > 0) ? $clog2(SCAN_LATENCY + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(SCAN_LATENCY);
  localparam logic [ITER_W-1:0] ITER_LAST =
    ITER_W'(MAX_ITER);

  state_t            state_q, state_d;
  grid_t             grid_q, grid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  status_t           status_q, status_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              any_empty;
  logic              all_single;
  logic              no_change;
  logic [ITER_W-1:0] iter_inc;

  grid_checker u_grid_checker (
    .i_Grid       (i_Scan_Grid),
    .o_Any_Empty  (any_empty),
    .o_All_Single (all_single)
  );

  assign no_change = (i_Scan_Grid == grid_q);
  assign iter_inc  = iter_q + 1'b1;

  // Next-state and next-output logic for the run FSM.
  always_comb begin
    state_d  = state_q;
    grid_d   = grid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    status_d = status_q;
    iter_d   = iter_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_Start && !i_Abort) begin
          state_d  = S_WAIT;
          grid_d   = i_Grid;
          busy_d   = 1'b1;
          status_d = NONE;
          iter_d   = '0;
          cnt_d    = CNT_LOAD;
        end
      end
      S_WAIT: begin
        if (i_Abort) begin
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          status_d = ABORTED;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          grid_d = i_Scan_Grid;
          iter_d = iter_inc;
          cnt_d  = CNT_LOAD;
          if (any_empty) begin
            status_d = CONTRA;
          end else if (all_single) begin
            status_d = SOLVED;
          end else if (no_change) begin
            status_d = STUCK;
          end else if (iter_inc == ITER_LAST) begin
            status_d = TIMEOUT;
          end
          if (any_empty || all_single || no_change ||
              iter_inc == ITER_LAST) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs, async active-low reset.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q  <= S_IDLE;
      grid_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      status_q <= NONE;
      iter_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grid_q   <= grid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      status_q <= status_d;
      iter_q   <= iter_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_Grid   = grid_q;
  assign o_Busy   = busy_q;
  assign o_Done   = done_q;
  assign o_Status = status_q;
  assign o_Iter   = iter_q;

endmodule

// File: tb/tb_sudoku_scan_controller.sv
// Directed bench for sudoku_scan_controller with a
// scripted one-stage scanner model and a result scoreboard.
module tb_sudoku_scan_controller;
  import sudoku_pkg::*;

  localparam int LAT  = 1;
  localparam int MAXI = 4;
  localparam int IW   = $clog2(MAXI + 1);

  typedef enum {M_ECHO, M_SOLVE, M_NARROW, M_CONTRA, M_TOGGLE} mode_t;

  typedef struct {
    status_t st;
    int      it;
    grid_t   g;
    string   tag;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  grid_t         grid_in;
  grid_t         scan_grid;
  grid_t         dut_grid;
  logic          busy;
  logic          done;
  status_t       status;
  logic [IW-1:0] iter;

  mode_t mode = M_ECHO;
  grid_t all_cand;
  grid_t solved;
  exp_t  sb[$];

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  sudoku_scan_controller #(
    .SCAN_LATENCY (LAT),
    .MAX_ITER     (MAXI)
  ) dut (
    .i_Clk       (clk),
    .i_Rst_n     (rst_n),
    .i_Start     (start),
    .i_Abort     (abort),
    .i_Grid      (grid_in),
    .i_Scan_Grid (scan_grid),
    .o_Grid      (dut_grid),
    .o_Busy      (busy),
    .o_Done      (done),
    .o_Status    (status),
    .o_Iter      (iter)
  );

  function automatic grid_t fill(cell_t v);
    grid_t r;
    for (int b = 0; b < 3; b++)
      for (int c = 0; c < 3; c++)
        for (int k = 0; k < 9; k++)
          r[b][c][k] = v;
    return r;
  endfunction

  function automatic grid_t model(grid_t g, mode_t m);
    grid_t r;
    r = g;
    case (m)
      M_SOLVE: r = solved;
      M_NARROW:
        if (g[0][0][8] == 9'h1FF) r[0][0][8] = 9'h180;
        else r[0][0][8] = 9'h100;
      M_CONTRA:
        if (g[0][0][0] == 9'h1FF) r[0][0][0] = 9'h1FE;
        else if (g[0][0][0] == 9'h1FE) r[0][0][0] = 9'h1FC;
        else r[2][0][2] = 9'h000;
      M_TOGGLE: r[1][1][4] = g[1][1][4] ^ 9'h001;
      default: r = g;
    endcase
    return r;
  endfunction

  // One-stage scanner model.
  always @(posedge clk) scan_grid <= model(dut_grid, mode);

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [728:0] obs,
                     logic [728:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Result monitor: pop the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_done observed=1 expected=0");
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({e.tag, "_status"}, status, e.st);
        chk({e.tag, "_iter"}, iter, e.it);
        chk({e.tag, "_grid"}, dut_grid, e.g);
        chk({e.tag, "_busy"}, busy, 0);
      end
    end
  end

  task automatic run(string tag, grid_t g, mode_t m,
                     status_t st, int it, grid_t eg);
    int n0;
    int c0;
    bit got;
    n0 = done_cnt;
    mode = m;
    grid_in = g;
    sb.push_back('{st, it, eg, tag});
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c0 = cyc;
    #1;
    chk({tag, "_busy_after_start"}, busy, 1);
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      #1;
      got = (done_cnt != n0);
    end
    chk({tag, "_done_seen"}, got, 1);
    if (got) chk({tag, "_latency"}, done_cyc - c0, it * (LAT + 1));
    else void'(sb.pop_back());
  endtask

  initial begin
    grid_t g3;
    grid_t g4;
    grid_t g6;
    int n0;
    bit got;

    all_cand = fill(ALL_CAND);
    for (int b = 0; b < 3; b++)
      for (int c = 0; c < 3; c++)
        for (int k = 0; k < 9; k++)
          solved[b][c][k] = 9'h001 << ((k + 3 * b + c) % 9);
    grid_in = all_cand;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_grid", dut_grid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_status", status, NONE);
    chk("rst_iter", iter, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: echo -> stuck after one pass.
    run("t1_stuck", all_cand, M_ECHO, STUCK, 1, all_cand);

    // 2: one-pass solve.
    run("t2_solve", all_cand, M_SOLVE, SOLVED, 1, solved);

    // 3: last cell narrowed over two passes.
    g3 = solved;
    g3[0][0][8] = ALL_CAND;
    run("t3_narrow", g3, M_NARROW, SOLVED, 2, solved);
    chk("t3_cell8", dut_grid[0][0][8], 9'h100);

    // 4: contradiction on pass 3.
    g4 = all_cand;
    g4[0][0][0] = 9'h1FC;
    g4[2][0][2] = 9'h000;
    run("t4_contra", all_cand, M_CONTRA, CONTRA, 3, g4);

    // 5: timeout after MAX_ITER passes.
    n0 = done_cnt;
    run("t5_timeout", all_cand, M_TOGGLE, TIMEOUT, MAXI, all_cand);
    repeat (5) @(negedge clk);
    #1;
    chk("t5_one_done", done_cnt - n0, 1);
    chk("t5_hold_status", status, TIMEOUT);

    // 6a: abort during pass 2.
    n0 = done_cnt;
    mode = M_TOGGLE;
    grid_in = all_cand;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (iter == IW'(1));
    end
    chk("t6a_pass1_seen", got, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    g6 = all_cand;
    g6[1][1][4] = 9'h1FE;
    chk("t6a_busy", busy, 0);
    chk("t6a_status", status, ABORTED);
    chk("t6a_iter", iter, 1);
    chk("t6a_grid", dut_grid, g6);
    repeat (6) @(negedge clk);
    #1;
    chk("t6a_no_done", done_cnt - n0, 0);

    // Abort beats start in idle.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    #1;
    chk("t6a_idle_abort_busy", busy, 0);
    chk("t6a_idle_abort_status", status, ABORTED);

    // 6b: start while busy is ignored.
    n0 = done_cnt;
    mode = M_ECHO;
    grid_in = all_cand;
    sb.push_back('{STUCK, 1, all_cand, "t6b_ignore"});
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    grid_in = solved;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("t6b_one_done", done_cnt - n0, 1);
    chk("t6b_idle_busy", busy, 0);

    // 6c: asynchronous reset mid-run.
    n0 = done_cnt;
    mode = M_TOGGLE;
    grid_in = all_cand;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6c_grid", dut_grid, 0);
    chk("t6c_busy", busy, 0);
    chk("t6c_done", done, 0);
    chk("t6c_status", status, NONE);
    chk("t6c_iter", iter, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("t6c_no_done", done_cnt - n0, 0);
    chk("t6c_stays_idle", busy, 0);

    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
